ula_sequenciador: RTL

Multi-cycle sequencer sitting in front of the combinational ULA: accepts one operation request at a time over a valid/ready handshake, drives the ULA operand and `controle` inputs from internal registers, and optionally re-issues the same operation several times with the result fed back as operand A (for example, a shift-left by N built from N single-bit shifts). It returns the final result plus flags over a second valid/ready handshake. It is the only driver of the ULA inputs in the datapath.

---
 rtl/ula_sequenciador_if.sv | 60 ++++++
 rtl/ula_sequenciador.sv | 125 ++++++++++++
 2 files changed

// File: rtl/ula_sequenciador_if.sv
// ula_sequenciador_if
// Bundles the three buses around the ULA sequencer:
//   - request handshake: pedido_valido/pedido_pronto plus controle, operands and
//     repeat count.
//   - ULA drive/return: operands and controle toward the combinational ULA,
//     result and Z/C/S/O flags back.
//   - response handshake: resp_valido/resp_pronto plus final result and flags,
//     and the ocupado status bit.
// Modports:
//   master - the sequencer itself.
//   slave  - the environment: requester, ULA and response consumer.
interface ula_sequenciador_if #(
   parameter int bits_palavra = 3,
   parameter int QTD_BITS     = 3
);
   logic                           pedido_valido;
   logic                           pedido_pronto;
   logic        [4:0]              pedido_controle;
   logic signed [bits_palavra-1:0] pedido_opA;
   logic signed [bits_palavra-1:0] pedido_opB;
   logic        [QTD_BITS-1:0]     pedido_qtd;

   logic signed [bits_palavra-1:0] ula_operandoA;
   logic signed [bits_palavra-1:0] ula_operandoB;
   logic        [4:0]              ula_controle;
   logic signed [bits_palavra-1:0] ula_resultado;
   logic                           ula_Z;
   logic                           ula_C;
   logic                           ula_S;
   logic                           ula_O;

   logic                           resp_valido;
   logic                           resp_pronto;
   logic signed [bits_palavra-1:0] resp_resultado;
   logic                           resp_Z;
   logic                           resp_C;
   logic                           resp_S;
   logic                           resp_O;
   logic                           ocupado;

   modport master (
      input  pedido_valido, pedido_controle, pedido_opA, pedido_opB, pedido_qtd,
      output pedido_pronto,
      output ula_operandoA, ula_operandoB, ula_controle,
      input  ula_resultado, ula_Z, ula_C, ula_S, ula_O,
      output resp_valido, resp_resultado, resp_Z, resp_C, resp_S, resp_O,
      input  resp_pronto,
      output ocupado
   );

   modport slave (
      output pedido_valido, pedido_controle, pedido_opA, pedido_opB, pedido_qtd,
      input  pedido_pronto,
      input  ula_operandoA, ula_operandoB, ula_controle,
      output ula_resultado, ula_Z, ula_C, ula_S, ula_O,
      input  resp_valido, resp_resultado, resp_Z, resp_C, resp_S, resp_O,
      output resp_pronto,
      input  ocupado
   );
endinterface

// File: rtl/ula_sequenciador.sv
// ula_sequenciador
// Multi-cycle sequencer in front of the combinational ULA. Accepts one request
// at a time, runs the ULA pedido_qtd+1 times with the result fed back into
// operand A (operand B held constant), then presents the final result and flags
// until the consumer takes them. Z/C/S come from the last execution; O is the
// OR of every execution of the request.
// Ports:
//   clock - rising-edge clock.
//   reset - asynchronous, active-high; aborts any request in flight.
//   bus   - ula_sequenciador_if.master: request, ULA and response buses.
module ula_sequenciador #(
   parameter int bits_palavra = 3,
   parameter int QTD_BITS     = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   ula_sequenciador_if.master    bus
);

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      EXECUTA  = 2'd1,
      RESPONDE = 2'd2
   } estado_t;

   estado_t estado, proximo;

   logic signed [bits_palavra-1:0] reg_A;
   logic signed [bits_palavra-1:0] reg_B;
   logic        [4:0]              reg_ctl;
   logic        [QTD_BITS-1:0]     contador;
   logic                           acc_O;

   logic signed [bits_palavra-1:0] resp_res;
   logic                           resp_z;
   logic                           resp_c;
   logic                           resp_s;
   logic                           resp_o;

   logic aceita;
   logic ultimo;

   assign aceita = (estado == OCIOSO) && bus.pedido_valido;
   assign ultimo = (estado == EXECUTA) && (contador == '0);

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) estado <= OCIOSO;
      else       estado <= proximo;
   end

   // Next-state logic
   always_comb begin
      proximo = estado;
      case (estado)
         OCIOSO:   if (bus.pedido_valido) proximo = EXECUTA;
         EXECUTA:  if (contador == '0)    proximo = RESPONDE;
         RESPONDE: if (bus.resp_pronto)   proximo = OCIOSO;
         default:                         proximo = OCIOSO;
      endcase
   end

   // Status outputs
   always_comb begin
      bus.pedido_pronto = 1'b0;
      bus.resp_valido   = 1'b0;
      bus.ocupado       = 1'b1;
      case (estado)
         OCIOSO: begin
            bus.pedido_pronto = 1'b1;
            bus.ocupado       = 1'b0;
         end
         RESPONDE: bus.resp_valido = 1'b1;
         default: ;
      endcase
   end

   // Operand/counter registers and response capture. The counter only
   // decrements while non-zero, so an all-ones count gives 2^QTD_BITS passes
   // without wrapping.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         reg_A    <= '0;
         reg_B    <= '0;
         reg_ctl  <= '0;
         contador <= '0;
         acc_O    <= 1'b0;
         resp_res <= '0;
         resp_z   <= 1'b0;
         resp_c   <= 1'b0;
         resp_s   <= 1'b0;
         resp_o   <= 1'b0;
      end else if (aceita) begin
         reg_A    <= bus.pedido_opA;
         reg_B    <= bus.pedido_opB;
         reg_ctl  <= bus.pedido_controle;
         contador <= bus.pedido_qtd;
         acc_O    <= 1'b0;
      end else if (estado == EXECUTA) begin
         acc_O <= acc_O | bus.ula_O;
         if (ultimo) begin
            resp_res <= bus.ula_resultado;
            resp_z   <= bus.ula_Z;
            resp_c   <= bus.ula_C;
            resp_s   <= bus.ula_S;
            resp_o   <= acc_O | bus.ula_O;
         end else begin
            reg_A    <= bus.ula_resultado;
            contador <= contador - 1'b1;
         end
      end
   end

   // ULA inputs come straight from registers, so they hold between requests.
   assign bus.ula_operandoA  = reg_A;
   assign bus.ula_operandoB  = reg_B;
   assign bus.ula_controle   = reg_ctl;

   assign bus.resp_resultado = resp_res;
   assign bus.resp_Z         = resp_z;
   assign bus.resp_C         = resp_c;
   assign bus.resp_S         = resp_s;
   assign bus.resp_O         = resp_o;

endmodule
